transit_sequencer: RTL and testbench
====================================

Name: transit_sequencer

Overview:
- Controller for the UART transit datapath (receiver, buffer, 4→7 encoder, 7→4 decoder, transmitter).
- Queues bytes from the UART buffer, splits each into two nibbles and drives them through the encoder/decoder pair in turn.
- Reassembles the decoded nibbles into a byte and starts the transmitter only when it is idle.
- Replaces the ad-hoc counter/flag glue at top level with one FSM that has a defined handshake and error handling.

Parameters:
- FIFO_DEPTH, 4, pending-byte queue depth; power of two, minimum 2.
- ACT_LEN, 3, cycles nib_active is held high per nibble.
- TIMEOUT, 255, maximum cycles to wait for dec_valid after nib_active falls.
- GUARD, 2, cycles after tx_enable before tx_busy is sampled again.

Ports:
- clk  in  1  codec-domain clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- byte_in  in  8  byte from the UART buffer.
- byte_valid  in  1  one-cycle strobe; byte_in is valid in the same cycle.
- nib_out  out  4  nibble to the encoder (bits_in).
- nib_active  out  1  encoder activate.
- dec_bits  in  4  decoded nibble.
- dec_valid  in  1  one-cycle strobe; dec_bits is valid in the same cycle.
- tx_byte  out  8  byte to the transmitter.
- tx_enable  out  1  one-cycle transmit start.
- tx_busy  in  1  transmitter busy.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- err_timeout  out  1  one-cycle pulse when a byte is aborted on timeout.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; working byte 0.
- Reset mid-operation aborts immediately. No tx_enable is issued for a partially processed byte.

FIFO:
- Push on byte_valid when not full.
- Push while full drops the byte and sets overflow (cleared only by reset).
- A push and a pop in the same cycle are both honoured. When full, the pop frees the slot and the push is accepted; overflow is not set.
- fifo_count updates the cycle after the event.

FSM states:
- IDLE: if fifo_count != 0, go to LOAD.
- LOAD (1 cycle): pop head into the working byte w; go to SEND_LO.
- SEND_LO (ACT_LEN cycles): nib_out = w[3:0], nib_active = 1; then go to WAIT_LO.
- WAIT_LO: nib_active = 0 and nib_out holds its value.
  - On dec_valid: lo <= dec_bits, go to SEND_HI.
  - If the timeout counter reaches TIMEOUT: pulse err_timeout, discard w, go to IDLE.
- SEND_HI / WAIT_HI: same as SEND_LO / WAIT_LO with w[7:4]; on dec_valid capture hi and go to TX_WAIT.
- TX_WAIT: tx_byte = {hi, lo} held stable. When tx_busy = 0, go to TX_FIRE.
- TX_FIRE (1 cycle): tx_enable = 1; go to GUARD.
- GUARD (GUARD cycles): tx_busy is ignored; then go to IDLE.

Timing and boundary rules:
- dec_valid during a SEND state is ignored. Only the WAIT states accept it.
- Timeout counter: width $clog2(TIMEOUT+1), cleared on entry to each WAIT state, saturating.
- tx_byte holds its value from TX_WAIT until the next TX_WAIT.
- Latency, empty FIFO and ideal decoder (dec_valid 2 cycles after nib_active falls), tx_busy = 0, cycle 0 = byte_valid:
  - cycle 1: fifo_count = 1, IDLE.
  - cycle 2: LOAD.
  - cycles 3–5: SEND_LO.
  - cycles 6–7: WAIT_LO.
  - cycles 8–10: SEND_HI.
  - cycles 11–12: WAIT_HI.
  - cycle 13: TX_WAIT.
  - cycle 14: tx_enable.
- Back-to-back byte throughput is one byte per (LOAD + 2·ACT_LEN + decode waits + TX + GUARD) cycles.

Optional Feature:
- Macro: TRANSIT_BYPASS_EN.
- When defined: adds input bypass (1 bit), sampled in LOAD.
  - If bypass = 1, the FSM goes LOAD → TX_WAIT with tx_byte = w.
  - The encoder/decoder are not driven and nib_active stays 0.
- When undefined: no bypass port; every byte goes through the codec.

Test Plan:
- Single byte 0xA5, decoder model returns the nibble after 2 cycles, tx_busy = 0:
  - nib_out = 0x5 then 0xA, each with nib_active high for 3 cycles.
  - tx_byte = 0xA5 and tx_enable high at cycle 14, exactly one pulse.
- Bytes 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 strobed on consecutive cycles with FIFO_DEPTH = 4:
  - The first pop frees one slot, so the transmitted sequence is 0x11, 0x22, 0x33, 0x44, 0x55.
  - 0x66 is dropped, overflow = 1, and fifo_count peaks at 4.
- tx_busy held at 1 for 50 cycles while byte 0x3C is processed:
  - FSM waits in TX_WAIT with tx_byte = 0x3C; tx_enable fires 1 cycle after tx_busy falls.
- Decoder never asserts dec_valid for byte 0x7E:
  - err_timeout pulses TIMEOUT cycles after entering WAIT_LO; no tx_enable.
  - The next queued byte 0x81 completes normally.
- Reset driven to 0 while in SEND_HI with 2 bytes queued:
  - All outputs 0 and fifo_count = 0 immediately (asynchronous).
  - After reset is released, no transmission occurs.
- With TRANSIT_BYPASS_EN, bypass = 1, byte 0xC3:
  - nib_active never asserts; tx_byte = 0xC3 with tx_enable at cycle 4.

Source files
------------

// File: rtl/transit_sequencer.sv
// Transit controller: queues UART bytes, runs each nibble through the 4->7/7->4 codec pair,
// reassembles the byte and hands it to the transmitter. Optional TRANSIT_BYPASS_EN skips the codec.
module transit_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ACT_LEN    = 3,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned GUARD      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid,
    output logic [3:0]                    nib_out,
    output logic                          nib_active,
    input  logic [3:0]                    dec_bits,
    input  logic                          dec_valid,
    output logic [7:0]                    tx_byte,
    output logic                          tx_enable,
    input  logic                          tx_busy,
`ifdef TRANSIT_BYPASS_EN
    input  logic                          bypass,
`endif
    output logic                          overflow,
    output logic                          err_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned PH_MAX = (ACT_LEN > GUARD) ? ACT_LEN : GUARD;
    localparam int unsigned PH_W  = $clog2(PH_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SEND_LO, S_WAIT_LO, S_SEND_HI, S_WAIT_HI,
        S_TX_WAIT, S_TX_FIRE, S_GUARD
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [7:0]         w_q, w_d;
    logic [3:0]         lo_q, lo_d;
    logic [3:0]         nib_q, nib_d;
    logic               nib_active_q, nib_active_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_enable_q, tx_enable_d;
    logic               err_q, err_d;
    logic               pop_c, push_ok_c;
    logic [7:0]         head_c;

    assign pop_c  = (state_q == S_LOAD);
    assign head_c = mem_q[rd_ptr_q];

    // FIFO: a pop in the same cycle frees the slot for a push even when full
    always_comb begin
        mem_d      = mem_q;
        push_ok_c  = byte_valid && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_c);
        overflow_d = overflow_q | (byte_valid & ~push_ok_c);
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = byte_in;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        count_d  = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        to_d      = to_q;
        w_d       = w_q;
        lo_d      = lo_q;
        nib_d     = nib_q;
        tx_byte_d = tx_byte_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                w_d  = head_c;
                ph_d = '0;
`ifdef TRANSIT_BYPASS_EN
                if (bypass) begin
                    state_d   = S_TX_WAIT;
                    tx_byte_d = head_c;
                end else begin
                    state_d = S_SEND_LO;
                    nib_d   = head_c[3:0];
                end
`else
                state_d = S_SEND_LO;
                nib_d   = head_c[3:0];
`endif
            end
            S_SEND_LO: begin
                nib_d = w_q[3:0];
                if (ph_q == PH_W'(ACT_LEN - 1)) begin
                    state_d = S_WAIT_LO;
                    to_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (dec_valid) begin
                    lo_d    = dec_bits;
                    nib_d   = w_q[7:4];
                    ph_d    = '0;
                    state_d = S_SEND_HI;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    w_d     = '0;
                    state_d = S_IDLE;
                end else if (to_q != TO_W'(TIMEOUT)) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_SEND_HI: begin
                if (ph_q == PH_W'(ACT_LEN - 1)) begin
                    state_d = S_WAIT_HI;
                    to_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (dec_valid) begin
                    tx_byte_d = {dec_bits, lo_q};
                    state_d   = S_TX_WAIT;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    w_d     = '0;
                    state_d = S_IDLE;
                end else if (to_q != TO_W'(TIMEOUT)) begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_TX_WAIT: begin
                if (!tx_busy) begin
                    state_d = S_TX_FIRE;
                end
            end
            S_TX_FIRE: begin
                ph_d    = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                // tx_busy is deliberately not looked at until the transmitter has had time to raise it
                if (ph_q == PH_W'(GUARD - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        nib_active_d = (state_d == S_SEND_LO) || (state_d == S_SEND_HI);
        tx_enable_d  = (state_d == S_TX_FIRE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            ph_q         <= '0;
            to_q         <= '0;
            w_q          <= '0;
            lo_q         <= '0;
            nib_q        <= '0;
            nib_active_q <= 1'b0;
            tx_byte_q    <= '0;
            tx_enable_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            ph_q         <= ph_d;
            to_q         <= to_d;
            w_q          <= w_d;
            lo_q         <= lo_d;
            nib_q        <= nib_d;
            nib_active_q <= nib_active_d;
            tx_byte_q    <= tx_byte_d;
            tx_enable_q  <= tx_enable_d;
            err_q        <= err_d;
        end
    end

    assign nib_out     = nib_q;
    assign nib_active  = nib_active_q;
    assign tx_byte     = tx_byte_q;
    assign tx_enable   = tx_enable_q;
    assign overflow    = overflow_q;
    assign err_timeout = err_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_transit_sequencer.sv
// Directed bench for transit_sequencer with a 2-cycle decoder model and a transmit monitor.
module tb_transit_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [3:0] nib_out;
    logic       nib_active;
    logic [3:0] dec_bits;
    logic       dec_valid;
    logic [7:0] tx_byte;
    logic       tx_enable;
    logic       tx_busy;
    logic       overflow;
    logic       err_timeout;
    logic [2:0] fifo_count;
`ifdef TRANSIT_BYPASS_EN
    logic       bypass;
`endif

    int checks = 0;
    int errors = 0;

    transit_sequencer dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .nib_out(nib_out), .nib_active(nib_active), .dec_bits(dec_bits),
        .dec_valid(dec_valid), .tx_byte(tx_byte), .tx_enable(tx_enable),
        .tx_busy(tx_busy),
`ifdef TRANSIT_BYPASS_EN
        .bypass(bypass),
`endif
        .overflow(overflow), .err_timeout(err_timeout), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Decoder model: returns the last activated nibble in the second cycle after nib_active falls
    logic       dec_en = 1'b0;
    logic       armed  = 1'b0;
    logic [3:0] saved  = 4'h0;
    int         low_n  = 0;
    initial begin
        dec_valid = 1'b0;
        dec_bits  = 4'h0;
    end
    always @(negedge clk) begin
        dec_valid = 1'b0;
        if (nib_active) begin
            saved = nib_out;
            low_n = 0;
            armed = dec_en;
        end else if (armed) begin
            low_n++;
            if (low_n == 2) begin
                dec_valid = 1'b1;
                dec_bits  = saved;
                armed     = 1'b0;
            end
        end
    end

    logic [7:0] txq [$];
    always @(negedge clk) begin
        if (tx_enable) txq.push_back(tx_byte);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_tx", 32'(txq.size()), 32'(n));
    endtask

    task automatic wait_nib(input logic level, input int budget);
        int k = 0;
        while (nib_active !== level && k < budget) begin
            tick();
            k++;
        end
        chk("wait_nib", 32'(nib_active), 32'(level));
    endtask

    logic       tr_na [0:20];
    logic [3:0] tr_no [0:20];
    logic       tr_te [0:20];
    logic [7:0] tr_tb [0:20];
    logic [2:0] tr_fc [0:20];

    initial begin
        int n;
        int peak;
        reset      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        tx_busy    = 1'b0;
`ifdef TRANSIT_BYPASS_EN
        bypass     = 1'b0;
`endif
        tick(); tick(); tick();
        chk("rst_nib_active", 32'(nib_active), 0);
        chk("rst_nib_out", 32'(nib_out), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_tx_enable", 32'(tx_enable), 0);
        chk("rst_flags", 32'({overflow, err_timeout}), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        reset = 1'b1;
        dec_en = 1'b1;
        tick();

        // Single byte 0xA5 with full cycle trace
        push(8'hA5);
        for (int c = 1; c <= 20; c++) begin
            tr_na[c] = nib_active; tr_no[c] = nib_out; tr_te[c] = tx_enable;
            tr_tb[c] = tx_byte;    tr_fc[c] = fifo_count;
            tick();
        end
        chk("a5_count_c1", 32'(tr_fc[1]), 1);
        chk("a5_count_c3", 32'(tr_fc[3]), 0);
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("a5_nib_active_c%0d", c), 32'(tr_na[c]),
                32'((c >= 3 && c <= 5) || (c >= 8 && c <= 10)));
            chk($sformatf("a5_tx_enable_c%0d", c), 32'(tr_te[c]), 32'(c == 14));
        end
        chk("a5_nib_lo", 32'(tr_no[3]), 32'h5);
        chk("a5_nib_lo_hold", 32'(tr_no[7]), 32'h5);
        chk("a5_nib_hi", 32'(tr_no[8]), 32'hA);
        chk("a5_tx_byte_c13", 32'(tr_tb[13]), 32'hA5);
        chk("a5_tx_byte_c14", 32'(tr_tb[14]), 32'hA5);
        chk("a5_tx_count", 32'(txq.size()), 1);
        txq.delete();

        // Six back-to-back bytes into a 4-deep queue
        byte_valid = 1'b1;
        peak = 0;
        for (int i = 1; i <= 6; i++) begin
            byte_in = 8'(8'h11 * i);
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_peak", 32'(peak), 4);
        wait_tx(5, 400);
        repeat (40) tick();
        chk("ovf_tx_total", 32'(txq.size()), 5);
        for (int i = 0; i < 5 && i < txq.size(); i++) begin
            chk($sformatf("ovf_tx_%0d", i), 32'(txq[i]), 32'(8'h11 * (i + 1)));
        end
        chk("ovf_sticky", 32'(overflow), 1);
        reset = 1'b0;
        tick();
        chk("ovf_cleared", 32'(overflow), 0);
        reset = 1'b1;
        tick();
        txq.delete();

        // Transmitter busy for 50 cycles
        tx_busy = 1'b1;
        push(8'h3C);
        repeat (50) tick();
        chk("busy_no_tx", 32'(txq.size()), 0);
        chk("busy_tx_byte", 32'(tx_byte), 32'h3C);
        chk("busy_tx_enable_low", 32'(tx_enable), 0);
        tx_busy = 1'b0;
        tick();
        chk("busy_fire", 32'(tx_enable), 1);
        tick();
        chk("busy_one_pulse", 32'(tx_enable), 0);
        chk("busy_tx_count", 32'(txq.size()), 1);
        repeat (10) tick();
        txq.delete();

        // Silent decoder for 0x7E, then 0x81 completes
        dec_en = 1'b0;
        push(8'h7E);
        push(8'h81);
        wait_nib(1'b1, 20);
        wait_nib(1'b0, 20);
        n = 0;
        while (!err_timeout && n < 400) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 255);
        dec_en = 1'b1;
        chk("to_no_tx", 32'(txq.size()), 0);
        tick();
        chk("to_one_pulse", 32'(err_timeout), 0);
        wait_tx(1, 100);
        if (txq.size() > 0) chk("to_next_byte", 32'(txq[0]), 32'h81);
        repeat (10) tick();
        txq.delete();

        // Asynchronous reset while the high nibble is being sent
        push(8'h5A);
        push(8'h6B);
        push(8'h7C);
        wait_nib(1'b1, 20);
        wait_nib(1'b0, 20);
        wait_nib(1'b1, 20);
        chk("rstmid_count_before", 32'(fifo_count), 2);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_nib_active", 32'(nib_active), 0);
        chk("rstmid_nib_out", 32'(nib_out), 0);
        chk("rstmid_tx", 32'({tx_byte, tx_enable}), 0);
        chk("rstmid_flags", 32'({overflow, err_timeout}), 0);
        chk("rstmid_fifo_count", 32'(fifo_count), 0);
        tick(); tick();
        reset = 1'b1;
        repeat (60) tick();
        chk("rstmid_no_tx", 32'(txq.size()), 0);
        chk("rstmid_nib_idle", 32'(nib_active), 0);

`ifdef TRANSIT_BYPASS_EN
        // Bypass skips the codec entirely
        bypass = 1'b1;
        push(8'hC3);
        for (int c = 1; c <= 8; c++) begin
            tr_na[c] = nib_active; tr_te[c] = tx_enable; tr_tb[c] = tx_byte;
            tick();
        end
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("byp_nib_active_c%0d", c), 32'(tr_na[c]), 0);
            chk($sformatf("byp_tx_enable_c%0d", c), 32'(tr_te[c]), 32'(c == 4));
        end
        chk("byp_tx_byte", 32'(tr_tb[4]), 32'hC3);
        bypass = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
